// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/flush/forwarding controller for the 5-stage pipeline.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_BITS   = 5,
  parameter int unsigned MD_CNT_W   = 8,
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned PERF_W     = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [REG_BITS-1:0] i_id_rs,
  input  logic [REG_BITS-1:0] i_id_rt,
  input  logic [REG_BITS-1:0] i_ex_rs,
  input  logic [REG_BITS-1:0] i_ex_rt,
  input  logic [REG_BITS-1:0] i_ex_rd,
  input  logic                i_ex_mem_read,
  input  logic [REG_BITS-1:0] i_mem_rd,
  input  logic                i_mem_reg_write,
  input  logic [REG_BITS-1:0] i_wb_rd,
  input  logic                i_wb_reg_write,
  input  logic                i_branch_taken,
  input  logic                i_md_start,
  input  logic                i_md_done,
  output logic                o_pc_en,
  output logic                o_ifid_en,
  output logic                o_idex_en,
  output logic                o_exmem_en,
  output logic                o_memwb_en,
  output logic                o_ifid_flush,
  output logic                o_idex_flush,
  output logic                o_exmem_flush,
  output logic [1:0]          o_fwd_a,
  output logic [1:0]          o_fwd_b,
  output logic                o_md_busy,
  output logic                o_md_err,
  output logic [PERF_W-1:0]   o_stall_cnt,
  output logic [PERF_W-1:0]   o_flush_cnt
);

  localparam logic [MD_CNT_W-1:0] MdLast = MD_CNT_W'(MD_TIMEOUT - 1);

  typedef enum logic [0:0] {StRun, StMdWait} state_e;

  state_e              r_state, w_state_nxt;
  logic [MD_CNT_W-1:0] r_md_cnt, w_md_cnt_nxt;
  logic                r_md_err, w_md_err_nxt;

  logic w_load_use;
  logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
  logic w_ifid_flush, w_idex_flush, w_exmem_flush, w_md_busy;
  logic w_mem_hit_a, w_wb_hit_a, w_mem_hit_b, w_wb_hit_b;
  logic [1:0] w_fwd_a, w_fwd_b;

  assign w_load_use = i_ex_mem_read && (i_ex_rd != '0) &&
                      ((i_ex_rd == i_id_rs) || (i_ex_rd == i_id_rt));

  always_comb begin
    w_pc_en       = 1'b1;
    w_ifid_en     = 1'b1;
    w_idex_en     = 1'b1;
    w_exmem_en    = 1'b1;
    w_memwb_en    = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    w_md_busy     = 1'b0;
    w_state_nxt   = r_state;
    w_md_cnt_nxt  = r_md_cnt;
    w_md_err_nxt  = r_md_err;
    unique case (r_state)
      StRun: begin
        if (i_branch_taken) begin
          w_ifid_flush = 1'b1;
          w_idex_flush = 1'b1;
        end else if (i_md_start) begin
          w_pc_en       = 1'b0;
          w_ifid_en     = 1'b0;
          w_idex_en     = 1'b0;
          w_exmem_flush = 1'b1;
          w_state_nxt   = StMdWait;
          w_md_cnt_nxt  = '0;
        end else if (w_load_use) begin
          w_pc_en      = 1'b0;
          w_ifid_en    = 1'b0;
          w_idex_flush = 1'b1;
        end
      end
      StMdWait: begin
        w_md_busy = 1'b1;
        if (i_md_done) begin
          w_state_nxt = StRun;
        end else begin
          // Hold the front end and keep bubbling EX/MEM until the result lands.
          w_pc_en       = 1'b0;
          w_ifid_en     = 1'b0;
          w_idex_en     = 1'b0;
          w_exmem_flush = 1'b1;
          if (r_md_cnt == MdLast) begin
            w_md_err_nxt = 1'b1;
            w_state_nxt  = StRun;
            w_md_cnt_nxt = '0;
          end else begin
            w_md_cnt_nxt = r_md_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = StRun;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= StRun;
      r_md_cnt <= '0;
      r_md_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
      r_md_err <= w_md_err_nxt;
    end
  end

  // MEM wins over WB when both hold the same destination.
  assign w_mem_hit_a = i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_ex_rs);
  assign w_wb_hit_a  = i_wb_reg_write  && (i_wb_rd  != '0) && (i_wb_rd  == i_ex_rs);
  assign w_mem_hit_b = i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_ex_rt);
  assign w_wb_hit_b  = i_wb_reg_write  && (i_wb_rd  != '0) && (i_wb_rd  == i_ex_rt);
  assign w_fwd_a = w_mem_hit_a ? 2'b10 : (w_wb_hit_a ? 2'b01 : 2'b00);
  assign w_fwd_b = w_mem_hit_b ? 2'b10 : (w_wb_hit_b ? 2'b01 : 2'b00);

  assign o_pc_en       = w_pc_en       & ~i_rst;
  assign o_ifid_en     = w_ifid_en     & ~i_rst;
  assign o_idex_en     = w_idex_en     & ~i_rst;
  assign o_exmem_en    = w_exmem_en    & ~i_rst;
  assign o_memwb_en    = w_memwb_en    & ~i_rst;
  assign o_ifid_flush  = w_ifid_flush  & ~i_rst;
  assign o_idex_flush  = w_idex_flush  & ~i_rst;
  assign o_exmem_flush = w_exmem_flush & ~i_rst;
  assign o_fwd_a       = i_rst ? 2'b00 : w_fwd_a;
  assign o_fwd_b       = i_rst ? 2'b00 : w_fwd_b;
  assign o_md_busy     = w_md_busy     & ~i_rst;
  assign o_md_err      = r_md_err;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] r_stall_cnt, r_flush_cnt;
  logic              w_branch_flush;

  assign w_branch_flush = (r_state == StRun) && i_branch_taken;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_en)       r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      if (w_branch_flush) r_flush_cnt <= r_flush_cnt + PERF_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl using an expected-value queue.
module tb_pipe_hazard_ctrl;
  localparam int unsigned RB = 5;
  localparam int unsigned CW = 8;
  localparam int unsigned TO = 64;
  localparam int unsigned PW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [RB-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic          ex_mem_read, mem_reg_write, wb_reg_write, branch_taken, md_start, md_done;
  logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, exmem_flush, md_busy, md_err;
  logic [1:0]    fwd_a, fwd_b;
  logic [PW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_BITS(RB), .MD_CNT_W(CW), .MD_TIMEOUT(TO), .PERF_W(PW)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_ex_rs(ex_rs), .i_ex_rt(ex_rt), .i_ex_rd(ex_rd),
    .i_ex_mem_read(ex_mem_read), .i_mem_rd(mem_rd), .i_mem_reg_write(mem_reg_write),
    .i_wb_rd(wb_rd), .i_wb_reg_write(wb_reg_write), .i_branch_taken(branch_taken),
    .i_md_start(md_start), .i_md_done(md_done),
    .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_idex_en(idex_en), .o_exmem_en(exmem_en),
    .o_memwb_en(memwb_en), .o_ifid_flush(ifid_flush), .o_idex_flush(idex_flush),
    .o_exmem_flush(exmem_flush), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
    .o_md_busy(md_busy), .o_md_err(md_err), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  // Bit order: pc ifid idex exmem memwb | ifid_fl idex_fl exmem_fl | fwd_a fwd_b | busy err
  logic [13:0] obs;
  assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
                exmem_flush, fwd_a, fwd_b, md_busy, md_err};

  localparam logic [13:0] MaskAll    = 14'h3FFF;
  localparam logic [13:0] MaskNoBusy = 14'h3FFD;

  typedef struct {
    string       tag;
    logic [13:0] vec;
    logic [13:0] mask;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;
  logic        exp_err = 1'b0;

  function automatic logic [13:0] ev(input logic pc, ifid, idex, exmem, memwb, fi, fd, fe,
                                     input logic [1:0] fa, fb, input logic busy, err);
    return {pc, ifid, idex, exmem, memwb, fi, fd, fe, fa, fb, busy, err};
  endfunction

  function automatic logic [13:0] norm();
    return ev(1, 1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, exp_err);
  endfunction

  function automatic logic [13:0] lu();
    return ev(0, 0, 1, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0, exp_err);
  endfunction

  function automatic logic [13:0] mds(input logic busy);
    return ev(0, 0, 0, 1, 1, 0, 0, 1, 2'b00, 2'b00, busy, exp_err);
  endfunction

  function automatic logic [13:0] fwd(input logic [1:0] fa, fb);
    return ev(1, 1, 1, 1, 1, 0, 0, 0, fa, fb, 0, exp_err);
  endfunction

  // One clock cycle: queue the expectation, compare at the falling edge, advance.
  task automatic cyc(input string tag, input logic [13:0] v, input logic [13:0] m);
    exp_t e;
    exp_t got;
    e.tag = tag; e.vec = v; e.mask = m;
    sb.push_back(e);
    if (!v[13] && !rst) exp_stall++;
    @(negedge clk);
    got = sb.pop_front();
    n_tests++;
    assert ((obs & got.mask) === (got.vec & got.mask)) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", got.tag, obs & got.mask,
             got.vec & got.mask);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string tag, input logic [PW-1:0] o, input logic [PW-1:0] x);
    n_tests++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, x);
    end
  endtask

  task automatic check1(input string tag, input logic o, input logic x);
    n_tests++;
    assert (o === x) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, o, x);
    end
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_mem_read = 0; mem_reg_write = 0; wb_reg_write = 0;
    branch_taken = 0; md_start = 0; md_done = 0;
  endtask

  initial begin
    // Reset forces every output low, even with forwarding/branch/md inputs active.
    rst = 1'b1;
    idle_inputs();
    ex_rs = 5'd3; mem_rd = 5'd3; mem_reg_write = 1; branch_taken = 1; md_start = 1;
    #2;
    cyc("reset", ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0), MaskAll);
    idle_inputs();
    rst = 1'b0;
    cyc("idle", norm(), MaskAll);

    // Load-use on rs: exactly one bubble.
    ex_mem_read = 1; ex_rd = 5'd5; id_rs = 5'd5;
    cyc("lu_rs", lu(), MaskAll);
    ex_mem_read = 0;
    cyc("lu_rs_after", norm(), MaskAll);

    // Register 0 never stalls.
    ex_mem_read = 1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    cyc("lu_r0", norm(), MaskAll);
    idle_inputs();

    // Mult/div: start at n, done at n+10.
    md_start = 1;
    cyc("md_start", mds(0), MaskAll);
    md_start = 0;
    for (int i = 1; i <= 9; i++) cyc("md_wait", mds(1), MaskAll);
    md_done = 1;
    cyc("md_done", norm(), MaskNoBusy);
    md_done = 0;
    cyc("md_after", norm(), MaskAll);

`ifdef PIPE_CTRL_PERF_EN
    check32("stall_cnt_t1t4", stall_cnt, 11);
    check32("flush_cnt_t1t4", flush_cnt, 0);
`else
    check32("stall_cnt_off", stall_cnt, 0);
    check32("flush_cnt_off", flush_cnt, 0);
`endif

    // Load-use on rt; a non-load with the same regs does not stall.
    ex_mem_read = 1; ex_rd = 5'd7; id_rs = 5'd2; id_rt = 5'd7;
    cyc("lu_rt", lu(), MaskAll);
    ex_mem_read = 0;
    cyc("nolu_rt", norm(), MaskAll);

    // Branch beats load-use and md_start.
    branch_taken = 1; ex_mem_read = 1; md_start = 1;
    exp_flush++;
    cyc("branch_prio", ev(1, 1, 1, 1, 1, 1, 1, 0, 2'b00, 2'b00, 0, exp_err), MaskAll);
    idle_inputs();
    cyc("branch_after", norm(), MaskAll);

    // Branch and md_start are ignored while waiting on mult/div.
    md_start = 1;
    cyc("md2_start", mds(0), MaskAll);
    md_start = 0;
    cyc("md2_wait", mds(1), MaskAll);
    branch_taken = 1; md_start = 1;
    cyc("md2_ignore", mds(1), MaskAll);
    idle_inputs();
    md_done = 1;
    cyc("md2_done", norm(), MaskNoBusy);
    md_done = 0;
    cyc("md2_after", norm(), MaskAll);

    // Forwarding priority and register 0.
    ex_rs = 5'd3; ex_rt = 5'd4; mem_rd = 5'd3; wb_rd = 5'd3; mem_reg_write = 1; wb_reg_write = 1;
    cyc("fwd_mem", fwd(2'b10, 2'b00), MaskAll);
    mem_reg_write = 0;
    cyc("fwd_wb", fwd(2'b01, 2'b00), MaskAll);
    ex_rt = 5'd3;
    cyc("fwd_wb_b", fwd(2'b01, 2'b01), MaskAll);
    ex_rs = 5'd0; ex_rt = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_write = 1;
    cyc("fwd_r0", fwd(2'b00, 2'b00), MaskAll);
    ex_rs = 5'd4; ex_rt = 5'd4; mem_rd = 5'd4; wb_rd = 5'd4;
    cyc("fwd_mem_ab", fwd(2'b10, 2'b10), MaskAll);
    idle_inputs();

    // Timeout: MD_TIMEOUT wait cycles without md_done, then sticky error in RUN.
    md_start = 1;
    cyc("to_start", mds(0), MaskAll);
    md_start = 0;
    for (int k = 0; k < int'(TO); k++) cyc("to_wait", mds(1), MaskAll);
    exp_err = 1'b1;
    cyc("to_run", norm(), MaskAll);
    cyc("to_sticky", norm(), MaskAll);

`ifdef PIPE_CTRL_PERF_EN
    check32("stall_cnt_model", stall_cnt, exp_stall);
    check32("flush_cnt_model", flush_cnt, exp_flush);
`endif

    // Reset in the middle of a wait drops busy at once and clears the error.
    md_start = 1;
    cyc("rst_md_start", mds(0), MaskAll);
    md_start = 0;
    check1("rst_busy_before", md_busy, 1'b1);
    rst = 1'b1;
    #1;
    check1("rst_busy_now", md_busy, 1'b0);
    check1("rst_pc_en_now", pc_en, 1'b0);
    check1("rst_err_now", md_err, 1'b0);
    exp_err = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("post_rst", norm(), MaskAll);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
